// File: rtl/reg_file_param_pkg.sv
// rtl/reg_file_param_pkg.sv - shared types and helpers for the parametrised register file
// Purpose: clear-engine state encoding, default width constants and the byte-lane
// merge used by both the write path and the same-cycle bypass.
// Ports: none (package).
package reg_file_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  localparam int DEF_DW = 32;
  localparam int BYTES  = DEF_DW / 8;

  // One byte lane of a byte-enabled write: enabled lanes take the new value.
  function automatic logic [7:0] merge(input logic [7:0] old_b,
                                       input logic [7:0] new_b,
                                       input logic       be);
    return be ? new_b : old_b;
  endfunction

endpackage

// File: rtl/reg_file_param_if.sv
// rtl/reg_file_param_if.sv - write/read/clear bus of the parametrised register file
// Purpose: bundles the decode-stage read ports, writeback write port and clear control.
// Ports: regWr/WriteAddr/WriteData/WriteBe (write), RdAddr/RdData (packed reads),
//        clrReq/clrBusy/wrDrop (soft clear). master drives requests, slave is the file.
interface reg_file_param_if
  import reg_file_pkg::*;
#(
  parameter int DW     = DEF_DW,
  parameter int DEPTH  = 32,
  parameter int NUM_RD = 2
);
  localparam int AW = $clog2(DEPTH);

  logic                   regWr;
  logic [AW-1:0]          WriteAddr;
  logic [DW-1:0]          WriteData;
  logic [DW/8-1:0]        WriteBe;
  logic [NUM_RD*AW-1:0]   RdAddr;
  logic [NUM_RD*DW-1:0]   RdData;
  logic                   clrReq;
  logic                   clrBusy;
  logic                   wrDrop;

  modport master (
    output regWr, WriteAddr, WriteData, WriteBe, RdAddr, clrReq,
    input  RdData, clrBusy, wrDrop
  );

  modport slave (
    input  regWr, WriteAddr, WriteData, WriteBe, RdAddr, clrReq,
    output RdData, clrBusy, wrDrop
  );

endinterface

// File: rtl/reg_file_param_clear.sv
// rtl/reg_file_param_clear.sv - sequential soft-clear engine
// Purpose: sweeps every register to zero, one per cycle, and flags writes lost to the sweep.
// Ports: clk_i, rst_ni (async active-low), clr_req_i, wr_attempt_i (valid write this cycle),
//        clr_we_o/clr_addr_o (zeroing strobe to the array), busy_o, wr_drop_o.
module rf_clear_ctrl
  import reg_file_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_req_i,
  input  logic          wr_attempt_i,
  output logic          clr_we_o,
  output logic [AW-1:0] clr_addr_o,
  output logic          busy_o,
  output logic          wr_drop_o
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  clr_state_e    state_q;
  logic [AW-1:0] cnt_q;
  logic          busy_q;
  logic          drop_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          drop_q <= 1'b0;
          if (clr_req_i) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        CLEAR: begin
          // clr_req_i is deliberately ignored here: a sweep never restarts.
          drop_q <= wr_attempt_i;
          if (cnt_q == LAST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + AW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign clr_we_o   = (state_q == CLEAR);
  assign clr_addr_o = cnt_q;
  assign busy_o     = busy_q;
  assign wr_drop_o  = drop_q;

endmodule

// File: rtl/reg_file_param.sv
// rtl/reg_file_param.sv - parametrised multi-port register file with byte enables and soft clear
// Purpose: decode-stage register file; combinational reads with optional write bypass,
//          byte-enabled writeback port, optional hardwired zero register.
// Ports: CLK, reset (async active-low), bus (reg_file_param_if.slave).
module reg_file_param
  import reg_file_pkg::*;
#(
  parameter int DW       = DEF_DW,
  parameter int DEPTH    = 32,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  parameter int AW       = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             reset,
  reg_file_param_if.slave  bus
);

  localparam int            NB      = DW / 8;
  localparam logic [AW:0]   DEPTH_L = (AW + 1)'(DEPTH);

  logic [DW-1:0] rf_q [DEPTH];
  logic          clr_we;
  logic [AW-1:0] clr_addr;
  logic          wr_valid;
  logic          wr_ok;
  logic [DW-1:0] wr_old;
  logic [DW-1:0] wr_new;

  // Storable address: in range and not the hardwired zero register.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return ({1'b0, a} < DEPTH_L) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  // wr_valid ignores the sweep so the clear engine can flag a dropped write.
  assign wr_valid = bus.regWr && addr_ok(bus.WriteAddr);
  assign wr_ok    = wr_valid && !clr_we;

  always_comb begin
    wr_old = addr_ok(bus.WriteAddr) ? rf_q[bus.WriteAddr] : '0;
    wr_new = wr_old;
    for (int b = 0; b < NB; b++) begin
      wr_new[8*b +: 8] = merge(wr_old[8*b +: 8], bus.WriteData[8*b +: 8], bus.WriteBe[b]);
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) rf_q[i] <= '0;
    end else if (clr_we) begin
      rf_q[clr_addr] <= '0;
    end else if (wr_ok) begin
      rf_q[bus.WriteAddr] <= wr_new;
    end
  end

  always_comb begin
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_word;
    bus.RdData = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd_addr = bus.RdAddr[k*AW +: AW];
      rd_word = addr_ok(rd_addr) ? rf_q[rd_addr] : '0;
      // wr_ok already excludes the zero register, out-of-range addresses and the sweep.
      if ((BYPASS != 0) && wr_ok && (rd_addr == bus.WriteAddr)) rd_word = wr_new;
      bus.RdData[k*DW +: DW] = rd_word;
    end
  end

  rf_clear_ctrl #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clear (
    .clk_i        (CLK),
    .rst_ni       (reset),
    .clr_req_i    (bus.clrReq),
    .wr_attempt_i (wr_valid),
    .clr_we_o     (clr_we),
    .clr_addr_o   (clr_addr),
    .busy_o       (bus.clrBusy),
    .wr_drop_o    (bus.wrDrop)
  );

endmodule

// File: tb/tb_reg_file_param.sv
// tb/tb_reg_file_param.sv - self-checking bench for reg_file_param (two builds)
module tb_reg_file_param;

  logic CLK = 1'b0;
  logic rst_n = 1'b0;
  always #5 CLK = ~CLK;

  // Shared stimulus for both builds.
  logic        wr = 1'b0;
  logic [4:0]  wa = '0;
  logic [31:0] wd = '0;
  logic [3:0]  be = '0;
  logic [4:0]  ra0 = '0;
  logic [4:0]  ra1 = '0;
  logic        clr = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  reg_file_param_if #(.DW(32), .DEPTH(32), .NUM_RD(2)) bus_a ();
  reg_file_param_if #(.DW(32), .DEPTH(20), .NUM_RD(2)) bus_b ();

  assign bus_a.regWr = wr;  assign bus_a.WriteAddr = wa;  assign bus_a.WriteData = wd;
  assign bus_a.WriteBe = be; assign bus_a.RdAddr = {ra1, ra0}; assign bus_a.clrReq = clr;
  assign bus_b.regWr = wr;  assign bus_b.WriteAddr = wa;  assign bus_b.WriteData = wd;
  assign bus_b.WriteBe = be; assign bus_b.RdAddr = {ra1, ra0}; assign bus_b.clrReq = clr;

  reg_file_param #(.DW(32), .DEPTH(32), .NUM_RD(2), .BYPASS(1), .ZERO_REG(1))
    dut_a (.CLK(CLK), .reset(rst_n), .bus(bus_a));
  reg_file_param #(.DW(32), .DEPTH(20), .NUM_RD(2), .BYPASS(0), .ZERO_REG(1))
    dut_b (.CLK(CLK), .reset(rst_n), .bus(bus_b));

  // Reference model: index 0 = build A, 1 = build B.
  logic [31:0] mem [2][32];
  int          dep [2] = '{32, 20};
  bit          byp [2] = '{1'b1, 1'b0};
  int          sw  [2];   // sweep position, -1 when idle
  bit          drp [2];

  function automatic bit storable(int m, int a);
    return (a < dep[m]) && (a != 0);
  endfunction

  function automatic logic [31:0] merged(logic [31:0] old);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] exp_rd(int m, int a);
    if (!storable(m, a)) return 32'h0;
    if (byp[m] && sw[m] < 0 && wr && int'(wa) == a) return merged(mem[m][a]);
    return mem[m][a];
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int a = 0; a < 32; a++) mem[m][a] = 32'h0;
      sw[m] = -1;
      drp[m] = 1'b0;
    end
  endtask

  task automatic model_edge(int m);
    if (sw[m] < 0) begin
      drp[m] = 1'b0;
      if (wr && storable(m, int'(wa))) mem[m][wa] = merged(mem[m][wa]);
      if (clr) sw[m] = 0;
    end else begin
      mem[m][sw[m]] = 32'h0;
      drp[m] = wr && storable(m, int'(wa));
      sw[m]++;
      if (sw[m] == dep[m]) sw[m] = -1;
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    #4;
    chk("a_rd0", bus_a.RdData[31:0],  exp_rd(0, int'(ra0)));
    chk("a_rd1", bus_a.RdData[63:32], exp_rd(0, int'(ra1)));
    chk("b_rd0", bus_b.RdData[31:0],  exp_rd(1, int'(ra0)));
    chk("b_rd1", bus_b.RdData[63:32], exp_rd(1, int'(ra1)));
    chk("a_busy", 32'(bus_a.clrBusy), 32'(sw[0] >= 0));
    chk("b_busy", 32'(bus_b.clrBusy), 32'(sw[1] >= 0));
    chk("a_drop", 32'(bus_a.wrDrop), 32'(drp[0]));
    chk("b_drop", 32'(bus_b.wrDrop), 32'(drp[1]));
  endtask

  task automatic wait_edge();
    @(posedge CLK);
    #1;
  endtask

  task automatic step();
    model_edge(0);
    model_edge(1);
    wait_edge();
  endtask

  initial begin
    int na, nb, nd, ndb;
    model_reset();
    wait_edge();

    // 1. reset state and first write
    ra0 = 5'd0; ra1 = 5'd1;
    check_all();
    chk("rst_rd1", bus_a.RdData[63:32], 32'h0);
    wait_edge();
    ra0 = 5'd16; ra1 = 5'd4;
    check_all();
    chk("rst_rd16", bus_a.RdData[31:0], 32'h0);
    rst_n = 1'b1;
    wait_edge();
    wr = 1'b1; wa = 5'd1; wd = 32'h00ab3591; be = 4'hF;
    check_all(); step();
    wr = 1'b0; ra0 = 5'd1;
    check_all();
    chk("t1_reg1", bus_a.RdData[31:0], 32'h00ab3591);
    step();

    // 2. zero register
    wr = 1'b1; wa = 5'd0; wd = 32'h1234fac9;
    check_all(); step();
    wr = 1'b0; ra0 = 5'd0;
    check_all();
    chk("t2_reg0", bus_a.RdData[31:0], 32'h0);
    chk("t2_drop", 32'(bus_a.wrDrop), 32'h0);
    step();
    wr = 1'b1; wa = 5'd16; wd = 32'h7632abcf;
    check_all(); step();
    wr = 1'b0; ra0 = 5'd16;
    check_all();
    chk("t2_reg16", bus_a.RdData[31:0], 32'h7632abcf);
    step();

    // 3. byte enables and bypass
    wr = 1'b1; wa = 5'd4; wd = 32'h98765432; be = 4'hF;
    check_all(); step();
    wd = 32'hAABBCCDD; be = 4'b0101; ra1 = 5'd4;
    check_all();
    chk("t3_byp_a", bus_a.RdData[63:32], 32'h98BB54DD);
    chk("t3_nobyp_b", bus_b.RdData[63:32], 32'h98765432);
    step();
    wr = 1'b0;
    check_all();
    chk("t3_after_a", bus_a.RdData[63:32], 32'h98BB54DD);
    chk("t3_after_b", bus_b.RdData[63:32], 32'h98BB54DD);
    step();

    // out-of-range address on the DEPTH=20 build
    wr = 1'b1; wa = 5'd25; wd = 32'h55AA55AA; be = 4'hF;
    check_all(); step();
    wr = 1'b0; ra0 = 5'd25;
    check_all();
    chk("oor_b_rd25", bus_b.RdData[31:0], 32'h0);
    chk("oor_a_rd25", bus_a.RdData[31:0], 32'h55AA55AA);
    step();

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      wr = 1'($urandom_range(0, 1)); wa = 5'($urandom); wd = $urandom; be = 4'($urandom);
      ra0 = 5'($urandom); ra1 = 5'($urandom);
      clr = ($urandom_range(0, 29) == 0);
      check_all(); step();
    end
    wr = 1'b0; clr = 1'b0;
    for (int i = 0; i < 40 && (sw[0] >= 0 || sw[1] >= 0); i++) begin
      check_all(); step();
    end

    // 4. full clear
    be = 4'hF;
    for (int a = 1; a < 32; a++) begin
      wr = 1'b1; wa = 5'(a); wd = (32'(a) * 32'h01000193) | 32'h1;
      check_all(); step();
    end
    wr = 1'b0; clr = 1'b1;
    check_all(); step();
    clr = 1'b0; na = 0; nb = 0;
    for (int i = 0; i < 100; i++) begin
      check_all();
      if (bus_a.clrBusy) na++;
      if (bus_b.clrBusy) nb++;
      if (!bus_a.clrBusy && !bus_b.clrBusy) break;
      step();
    end
    chk("t4_busy_a", 32'(na), 32'd32);
    chk("t4_busy_b", 32'(nb), 32'd20);
    step();
    for (int a = 0; a < 32; a++) begin
      ra0 = 5'(a); ra1 = 5'(31 - a);
      check_all();
      chk("t4_zero", bus_a.RdData[31:0], 32'h0);
      step();
    end

    // 5. write and clrReq re-pulse during the sweep
    wr = 1'b1; wa = 5'd31; wd = 32'h13572468;
    check_all(); step();
    wr = 1'b0; clr = 1'b1;
    check_all(); step();
    clr = 1'b0; na = 0; nd = 0; ndb = 0;
    for (int i = 0; i < 100; i++) begin
      wr = (sw[0] == 5); wa = 5'd31; wd = 32'hDEADBEEF;
      clr = (sw[0] == 8);
      check_all();
      if (bus_a.clrBusy) na++;
      if (bus_a.wrDrop) nd++;
      if (bus_b.wrDrop) ndb++;
      if (!bus_a.clrBusy && !bus_b.clrBusy && i > 8) break;
      step();
    end
    wr = 1'b0; clr = 1'b0;
    chk("t5_busy_a", 32'(na), 32'd32);
    chk("t5_drop_a", 32'(nd), 32'd1);
    chk("t5_drop_b", 32'(ndb), 32'd0);
    step();
    ra0 = 5'd31;
    check_all();
    chk("t5_reg31", bus_a.RdData[31:0], 32'h0);
    step();

    // 6. reset in the middle of a sweep
    for (int a = 5; a <= 7; a += 2) begin
      wr = 1'b1; wa = 5'(a); wd = 32'hC0DE0000 | 32'(a);
      check_all(); step();
    end
    wr = 1'b0; clr = 1'b1; ra0 = 5'd5; ra1 = 5'd7;
    check_all(); step();
    clr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check_all(); step();
    end
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t6_busy_a", 32'(bus_a.clrBusy), 32'h0);
    chk("t6_busy_b", 32'(bus_b.clrBusy), 32'h0);
    chk("t6_rd5", bus_a.RdData[31:0], 32'h0);
    chk("t6_rd7", bus_a.RdData[63:32], 32'h0);
    wait_edge();
    rst_n = 1'b1;
    check_all(); step();
    wr = 1'b1; wa = 5'd7; wd = 32'h0BADF00D;
    check_all(); step();
    wr = 1'b0;
    check_all();
    chk("t6_post_a", bus_a.RdData[63:32], 32'h0BADF00D);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
